// File: rtl/reg_file_reader_32x32.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_reader_32x32
// Purpose  : Walks a window of the 32x32 register file and streams each entry
//            as an (index, data) beat over valid/ready. Optional build macro
//            READER_SKIP_ZERO_EN suppresses beats for entries that read as 0.
// Revision : 1.0
// ============================================================================
module reg_file_reader_32x32 #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 5
) (
    input  logic                   clock,
    input  logic                   clear_n,
    input  logic                   start,
    input  logic [INDEX_WIDTH-1:0] first_index,
    input  logic [INDEX_WIDTH:0]   count,
    output logic [INDEX_WIDTH-1:0] read_index,
    input  logic [DATA_WIDTH-1:0]  read_value,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INDEX_WIDTH-1:0] out_index,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   busy,
    output logic                   done
);

    localparam logic [INDEX_WIDTH:0] C_DEPTH = {1'b1, {INDEX_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_q,     state_d;
    logic [INDEX_WIDTH-1:0] idx_q,       idx_d;
    logic [INDEX_WIDTH:0]   remaining_q, remaining_d;
    logic                   out_valid_q, out_valid_d;
    logic [INDEX_WIDTH-1:0] out_index_q, out_index_d;
    logic [DATA_WIDTH-1:0]  out_data_q,  out_data_d;
    logic                   done_q,      done_d;
    logic                   slot_free;

    assign slot_free = !out_valid_q || out_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        remaining_d = remaining_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d       = first_index;
                    remaining_d = (count > C_DEPTH) ? C_DEPTH : count;
                    state_d     = (count == '0) ? DRAIN : READ;
                end
            end

            READ: begin
                if (slot_free) begin
                    idx_d       = idx_q + INDEX_WIDTH'(1);
                    remaining_d = remaining_q - (INDEX_WIDTH+1)'(1);
                    if (remaining_q == (INDEX_WIDTH+1)'(1)) begin
                        state_d = DRAIN;
                    end
`ifdef READER_SKIP_ZERO_EN
                    // A zero entry is visited but produces no beat; the slot is free so valid drops.
                    if (read_value == '0) begin
                        out_valid_d = 1'b0;
                    end else begin
                        out_valid_d = 1'b1;
                        out_index_d = idx_q;
                        out_data_d  = read_value;
                    end
`else
                    out_valid_d = 1'b1;
                    out_index_d = idx_q;
                    out_data_d  = read_value;
`endif
                end
            end

            DRAIN: begin
                if (slot_free) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            remaining_q <= remaining_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    assign read_index = idx_q;
    assign out_valid  = out_valid_q;
    assign out_index  = out_index_q;
    assign out_data   = out_data_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_reg_file_reader_32x32.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_reg_file_reader_32x32
// Purpose  : Directed stimulus with a scan-level scoreboard model for
//            reg_file_reader_32x32 (READER_SKIP_ZERO_EN aware).
// Revision : 1.0
// ============================================================================
module tb_reg_file_reader_32x32;
    localparam int DW = 32;
    localparam int IW = 5;

    logic          clock = 1'b0;
    logic          clear_n = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [IW-1:0] first_index = '0;
    logic [IW:0]   count = '0;
    logic [IW-1:0] read_index, out_index;
    logic [DW-1:0] read_value, out_data;
    logic          out_valid, busy, done;

    logic [DW-1:0] mem [32];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    assign read_value = mem[read_index];

    reg_file_reader_32x32 #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
        .clock(clock), .clear_n(clear_n), .start(start),
        .first_index(first_index), .count(count),
        .read_index(read_index), .read_value(read_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_data(out_data),
        .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scan-level model ----------------
    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         exp_q[$];
    beat_t         cur;
    beat_t         b;
    logic [IW-1:0] seen_i[$];
    logic [DW-1:0] seen_d[$];
    bit            active = 0, act_b = 0, full_rate = 0, prev_valid = 0, prev_hs = 0;
    bit            prod [32];
    bit            ev;
    int            acc = 0, nscan = 0, presented = 0, dones = 0, done_cyc = 0, busy_cnt = 0, k_m = 0;
    logic [IW-1:0] first_m = '0;
    logic [IW-1:0] ri_exp;

    always @(negedge clock) begin
        if (!clear_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_read_index", read_index, 0);
            chk("rst_out_index", out_index, 0);
            chk("rst_out_data", out_data, 0);
            exp_q.delete();
            active = 0; full_rate = 0; prev_valid = 0; prev_hs = 0;
            first_m = '0; presented = 0;
        end else begin
            act_b = active;
            // Exact cycle shape of a scan whose consumer never stalled
            if (active && full_rate && cyc >= acc) begin
                k_m = cyc - acc;
                ev  = (k_m >= 1 && k_m <= nscan) ? prod[k_m-1] : 1'b0;
                chk("valid_timing", out_valid, ev);
                chk("done_timing", done, (k_m == nscan + 1));
            end
            if (out_valid && (!prev_valid || prev_hs)) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_beat: got index %0d data %0d, expected no beat (cycle %0d)", out_index, out_data, cyc);
                end else begin
                    cur = exp_q.pop_front();
                    seen_i.push_back(out_index);
                    seen_d.push_back(out_data);
                    presented++;
                end
            end
            if (out_valid) begin
                chk("out_index", out_index, cur.idx);
                chk("out_data", out_data, cur.data);
            end
            if (done) begin
                if (!active) begin
                    checks++; errors++;
                    $display("FAIL spurious_done: got done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    chk("done_beats_left", exp_q.size(), 0);
                    chk("done_valid", out_valid, 0);
                    chk("done_after_accept", prev_valid && !prev_hs, 0);
                end
                active = 0; dones++; done_cyc = cyc;
            end
            chk("busy", busy, act_b && !done);
            if (busy) busy_cnt++;
`ifndef READER_SKIP_ZERO_EN
            ri_exp = first_m + IW'(presented);
            chk("read_index", read_index, ri_exp);
`endif
            if (start && !active) begin
                active = 1; full_rate = 1; acc = cyc + 1;
                first_m = first_index; presented = 0;
                nscan = (count > 6'd32) ? 32 : int'(count);
                for (int j = 0; j < nscan; j++) begin
                    b.idx  = first_index + IW'(j);
                    b.data = mem[b.idx];
`ifdef READER_SKIP_ZERO_EN
                    prod[j] = (b.data != 0);
`else
                    prod[j] = 1'b1;
`endif
                    if (prod[j]) exp_q.push_back(b);
                end
            end else if (active) begin
                full_rate = full_rate && out_ready;
            end
            prev_valid = out_valid;
            prev_hs    = out_valid && out_ready;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic launch(input logic [IW-1:0] f, input logic [IW:0] c);
        start = 1'b1; first_index = f; count = c;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int d0;
        int n;
        d0 = dones; n = 0;
        while (dones == d0 && n < max) begin
            tick();
            n++;
        end
        if (dones == d0) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected one", max);
        end
        tick();
    endtask

    task automatic clear_seen();
        seen_i.delete();
        seen_d.delete();
        busy_cnt = 0;
    endtask

    initial begin
        int d0;
        int n;
        for (int i = 0; i < 32; i++) mem[i] = DW'(i * 3);
        out_ready = 1'b1;
        repeat (3) tick();
        clear_n = 1'b1;
        tick();

        // Reset in the middle of a scan
        clear_seen();
        launch(5'd0, 6'd8);
        n = 0;
        while (seen_i.size() < 3 && n < 20) begin
            @(negedge clock); #1; n++;
        end
        chk("beats_before_reset", seen_i.size(), 3);
        d0 = dones;
        #1 clear_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_out_index", out_index, 0);
        chk("async_rst_out_data", out_data, 0);
        chk("async_rst_read_index", read_index, 0);
        tick(); tick();
        clear_n = 1'b1;
        tick(); tick();
        chk("no_done_on_reset", dones - d0, 0);
        clear_seen();
        launch(5'd0, 6'd8);
        wait_done(40);
        chk("rerun_beats", seen_i.size(), 8);

        // Full dump
        clear_seen();
        launch(5'd0, 6'd32);
        wait_done(60);
        chk("dump_beats", seen_i.size(), 32);
        chk("dump_last_index", seen_i[31], 31);
        chk("dump_last_data", seen_d[31], 93);
        chk("dump_done_latency", done_cyc - acc, 33);
        chk("dump_busy_cycles", busy_cnt, 33);

        // Wrap and clamp
        clear_seen();
        d0 = dones;
        launch(5'd30, 6'd40);
        wait_done(60);
        chk("wrap_beats", seen_i.size(), 32);
        chk("wrap_idx0", seen_i[0], 30);
        chk("wrap_idx1", seen_i[1], 31);
        chk("wrap_idx2", seen_i[2], 0);
        chk("wrap_idx31", seen_i[31], 29);
        chk("wrap_dones", dones - d0, 1);

        // Backpressure
        clear_seen();
        launch(5'd5, 6'd3);
        out_ready = 1'b1; tick();
        out_ready = 1'b0; tick();
        out_ready = 1'b0; tick();
        out_ready = 1'b1; tick();
        out_ready = 1'b1; tick();
        out_ready = 1'b0; tick();
        out_ready = 1'b1;
        wait_done(30);
        chk("bp_beats", seen_i.size(), 3);
        chk("bp_idx0", seen_i[0], 5);
        chk("bp_idx2", seen_i[2], 7);
        chk("bp_data1", seen_d[1], 18);

        // Zero count
        clear_seen();
        launch(5'd9, 6'd0);
        wait_done(10);
        chk("zero_beats", seen_i.size(), 0);
        chk("zero_done_latency", done_cyc - acc, 1);

        // Start while busy is ignored
        clear_seen();
        d0 = dones;
        launch(5'd10, 6'd4);
        tick();
        launch(5'd20, 6'd4);
        wait_done(20);
        repeat (10) tick();
        chk("busy_start_beats", seen_i.size(), 4);
        chk("busy_start_last", seen_i[3], 13);
        chk("busy_start_dones", dones - d0, 1);

        // Sparse contents
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[1] = 32'd25;
        mem[4] = 32'd3739;
        clear_seen();
        launch(5'd0, 6'd8);
        wait_done(30);
`ifdef READER_SKIP_ZERO_EN
        chk("sparse_beats", seen_i.size(), 2);
        chk("sparse_idx0", seen_i[0], 1);
        chk("sparse_data0", seen_d[0], 25);
        chk("sparse_idx1", seen_i[1], 4);
        chk("sparse_data1", seen_d[1], 3739);
`else
        chk("sparse_beats", seen_i.size(), 8);
        chk("sparse_data0", seen_d[0], 0);
        chk("sparse_data1", seen_d[1], 25);
        chk("sparse_data4", seen_d[4], 3739);
`endif

        // All-zero window
        clear_seen();
        d0 = dones;
        launch(5'd8, 6'd5);
        wait_done(30);
`ifdef READER_SKIP_ZERO_EN
        chk("allzero_beats", seen_i.size(), 0);
`else
        chk("allzero_beats", seen_i.size(), 5);
`endif
        chk("allzero_dones", dones - d0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
